huffman_header_loader: RTL and testbench

HUFFMAN_HEADER_LOADER -- requirements
Module: huffman_header_loader

---
 rtl/huffman_pkg.sv | 19 +
 rtl/huffman_header_loader_ack_timer.sv | 20 ++
 rtl/huffman_header_loader.sv | 151 +++++++++++++++
 tb/tb_huffman_header_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman header loader and the code-table block.
package huffman_pkg;

    localparam int MAX_CODE_LEN = 12;
    localparam int LEN_W        = 4;
    localparam int PATH_W       = 12;
    localparam int SYM_W        = 8;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        CHAR,
        LENHI,
        PATHLO,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/huffman_header_loader_ack_timer.sv
// Counts WRITE cycles spent waiting for the table-write acknowledge.
module ack_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != 4'hF)) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/huffman_header_loader.sv
// Parses a byte-stream Huffman header (count, then char/len+path entries)
// and writes each valid entry to the code table with an acknowledge handshake.
module huffman_header_loader
    import huffman_pkg::*;
#(
    parameter int MAX_LEN     = MAX_CODE_LEN,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              save_comp,
    output logic              enable,
    output logic [LEN_W-1:0]  length,
    output logic [PATH_W-1:0] path,
    output logic [SYM_W-1:0]  character,
    output logic [8:0]        entry_count,
    output logic              busy,
    output logic              done,
    output logic              hdr_error
);

    function automatic logic len_ok(input logic [LEN_W-1:0] len);
        return (len != '0) && (int'(len) <= MAX_LEN);
    endfunction

    state_t      state, state_nxt;
    logic [8:0]  n_total;
    logic [8:0]  seen;
    logic [8:0]  seen_nxt;
    logic        last_entry;
    logic        xfer;
    logic        timer_clear;
    logic        timer_expired;
    logic [3:0]  timer_count;

    assign rx_ready = (state == COUNT) || (state == CHAR) ||
                      (state == LENHI) || (state == PATHLO);
    assign enable   = (state == WRITE);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign xfer     = rx_valid && rx_ready;

    // seen counts every parsed entry, including skipped ones, so N is honoured.
    assign seen_nxt      = seen + 9'd1;
    assign last_entry    = (seen_nxt == n_total);
    assign timer_expired = (timer_count == 4'(ACK_TIMEOUT - 1));

    ack_timer u_ack_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .inc   (enable),
        .count (timer_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_clear = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = COUNT;
            COUNT:  if (xfer) state_nxt = CHAR;
            CHAR:   if (xfer) state_nxt = LENHI;
            LENHI:  if (xfer) state_nxt = PATHLO;
            PATHLO: begin
                if (xfer) begin
                    if (len_ok(length)) begin
                        state_nxt   = WRITE;
                        timer_clear = 1'b1;
                    end else begin
                        state_nxt = last_entry ? DONE : CHAR;
                    end
                end
            end
            WRITE: begin
                if (save_comp) begin
                    state_nxt = last_entry ? DONE : CHAR;
                end else if (timer_expired) begin
                    state_nxt = IDLE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_total     <= '0;
            seen        <= '0;
            length      <= '0;
            path        <= '0;
            character   <= '0;
            entry_count <= '0;
            hdr_error   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        entry_count <= '0;
                        seen        <= '0;
                        hdr_error   <= 1'b0;
                    end
                end
                COUNT: begin
                    // A count byte of zero encodes a full 256-entry table.
                    if (xfer) n_total <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                end
                CHAR: begin
                    if (xfer) character <= rx_data;
                end
                LENHI: begin
                    if (xfer) begin
                        length      <= rx_data[7:4];
                        path[11:8]  <= rx_data[3:0];
                    end
                end
                PATHLO: begin
                    if (xfer) begin
                        path[7:0] <= rx_data;
                        if (!len_ok(length)) begin
                            hdr_error <= 1'b1;
                            seen      <= seen_nxt;
                        end
                    end
                end
                WRITE: begin
                    if (save_comp) begin
                        entry_count <= entry_count + 9'd1;
                        seen        <= seen_nxt;
                    end else if (timer_expired) begin
                        hdr_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_header_loader.sv
// Directed bench for huffman_header_loader with a write scoreboard.
module tb_huffman_header_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        save_comp;
    logic        enable;
    logic [3:0]  length;
    logic [11:0] path;
    logic [7:0]  character;
    logic [8:0]  entry_count;
    logic        busy;
    logic        done;
    logic        hdr_error;

    int checks = 0;
    int errors = 0;

    // ack_mode: 0 = tied to enable, 1 = delayed by ack_delay cycles, 2 = never
    int ack_mode  = 0;
    int ack_delay = 5;
    int wait_cnt  = 0;
    bit toggle    = 0;

    logic [23:0] exp_q[$];
    int done_cnt, write_cnt, hs_cnt, run, max_run, stable_err;
    logic [23:0] held;

    always #5 clk = ~clk;

    huffman_header_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .save_comp   (save_comp),
        .enable      (enable),
        .length      (length),
        .path        (path),
        .character   (character),
        .entry_count (entry_count),
        .busy        (busy),
        .done        (done),
        .hdr_error   (hdr_error)
    );

    assign save_comp = (ack_mode == 0) ? enable :
                       (ack_mode == 1) ? (enable && (wait_cnt >= ack_delay)) : 1'b0;

    always @(posedge clk) begin
        wait_cnt <= (enable && !save_comp) ? wait_cnt + 1 : 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid && rx_ready) hs_cnt++;
        if (done) done_cnt++;
        if (enable) begin
            run++;
            if (run > max_run) max_run = run;
            if (run == 1) held = {character, length, path};
            else if ({character, length, path} !== held) stable_err++;
            if (save_comp) begin
                write_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {character, length, path}, 24'hFFFFFF);
                end else begin
                    check("write_entry", {character, length, path}, exp_q.pop_front());
                end
            end
        end else begin
            run = 0;
        end
    end

    task automatic clear_stats();
        done_cnt = 0; write_cnt = 0; hs_cnt = 0;
        run = 0; max_run = 0; stable_err = 0;
        exp_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        if (toggle) begin
            rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rx_ready) begin
            check("send_stall", 32'(rx_ready), 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_entry(input logic [7:0] ch, input logic [3:0] len,
                              input logic [11:0] p, input bit expect_write);
        if (expect_write) exp_q.push_back({ch, len, p});
        send(ch);
        send({len, p[11:8]});
        send(p[7:0]);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic nominal_load(input string tag);
        clear_stats();
        pulse_start();
        send(8'd2);
        send_entry(8'h41, 4'd3, 12'h005, 1'b1);
        send_entry(8'h42, 4'd12, 12'h0AB, 1'b1);
        wait_idle(100);
        check({tag, "_entry_count"}, 32'(entry_count), 32'd2);
        check({tag, "_writes"}, 32'(write_cnt), 32'd2);
        check({tag, "_done"}, 32'(done_cnt), 32'd1);
        check({tag, "_hdr_error"}, 32'(hdr_error), 32'd0);
        check({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rx_data = '0; rx_valid = 1'b0;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {rx_ready, enable, busy, done, hdr_error, entry_count},
              32'd0);
        check("rst_data", {character, length, path}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", 32'(rx_ready), 32'd0);

        // Nominal two-entry load
        ack_mode = 0;
        nominal_load("nominal");

        // Back-pressure: rx_valid drops between every byte
        toggle = 1;
        nominal_load("backpressure");
        check("bp_handshakes", 32'(hs_cnt), 32'd7);
        toggle = 0;

        // Delayed acknowledge
        ack_mode = 1; ack_delay = 5;
        clear_stats();
        pulse_start();
        send(8'd1);
        send_entry(8'h55, 4'd4, 12'h234, 1'b1);
        wait_idle(100);
        check("delay_enable_cycles", 32'(max_run), 32'd6);
        check("delay_stable", 32'(stable_err), 32'd0);
        check("delay_entry_count", 32'(entry_count), 32'd1);
        check("delay_done", 32'(done_cnt), 32'd1);

        // Acknowledge never arrives
        ack_mode = 2;
        clear_stats();
        pulse_start();
        send(8'd1);
        send_entry(8'h66, 4'd5, 12'h011, 1'b0);
        wait_idle(100);
        check("timeout_enable_cycles", 32'(max_run), 32'd15);
        check("timeout_hdr_error", 32'(hdr_error), 32'd1);
        check("timeout_done", 32'(done_cnt), 32'd0);
        check("timeout_entry_count", 32'(entry_count), 32'd0);
        check("timeout_enable_low", 32'(enable), 32'd0);

        // Illegal lengths are skipped but still counted toward N
        ack_mode = 0;
        clear_stats();
        pulse_start();
        check("start_clears_error", 32'(hdr_error), 32'd0);
        send(8'd4);
        send_entry(8'h10, 4'd1, 12'h001, 1'b1);
        send_entry(8'h11, 4'hD, 12'hFFF, 1'b0);
        send_entry(8'h13, 4'd0, 12'h000, 1'b0);
        send_entry(8'h12, 4'd2, 12'h003, 1'b1);
        wait_idle(100);
        check("badlen_writes", 32'(write_cnt), 32'd2);
        check("badlen_entry_count", 32'(entry_count), 32'd2);
        check("badlen_hdr_error", 32'(hdr_error), 32'd1);
        check("badlen_done", 32'(done_cnt), 32'd1);
        check("badlen_sb_left", 32'(exp_q.size()), 32'd0);

        // Start while busy is ignored: a second start mid-load must not restart
        clear_stats();
        pulse_start();
        send(8'd1);
        pulse_start();
        send_entry(8'h77, 4'd6, 12'h03F, 1'b1);
        wait_idle(100);
        check("busy_start_entry_count", 32'(entry_count), 32'd1);
        check("busy_start_done", 32'(done_cnt), 32'd1);

        // Reset while the loader sits in LENHI
        clear_stats();
        pulse_start();
        send(8'd5);
        send(8'h20);
        rst = 1'b1;
        #1;
        check("midrst_ctrl", {rx_ready, enable, busy, done, hdr_error, entry_count},
              32'd0);
        check("midrst_data", {character, length, path}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_write", 32'(write_cnt), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);

        // Full 256-entry table (count byte 0)
        clear_stats();
        pulse_start();
        send(8'd0);
        for (int i = 0; i < 256; i++) begin
            send_entry(8'(i), 4'(1 + (i % 12)), 12'(i * 13), 1'b1);
        end
        wait_idle(100);
        check("wrap_entry_count", 32'(entry_count), 32'd256);
        check("wrap_done", 32'(done_cnt), 32'd1);
        check("wrap_hdr_error", 32'(hdr_error), 32'd0);
        check("wrap_sb_left", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
